// File: rtl/coffee_pkg.sv
// Shared types and decode helpers for the coffee machine order sequencer.
package coffee_pkg;

    typedef enum logic [2:0] {
        RCP_MILK_SUGAR     = 3'd0,
        RCP_MILK           = 3'd1,
        RCP_ESPRESSO_SUGAR = 3'd2,
        RCP_ESPRESSO       = 3'd3,
        RCP_CAPPU_SUGAR    = 3'd4,
        RCP_CAPPU          = 3'd5,
        RCP_BAD6           = 3'd6,
        RCP_BAD7           = 3'd7
    } recipe_e;

    // Ingredient indices, matching the encoding of refill_sel.
    localparam logic [1:0] ING_BEANS = 2'd0;
    localparam logic [1:0] ING_MILK  = 2'd1;
    localparam logic [1:0] ING_SUGAR = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_WAIT_CUP,
        ST_BREW,
        ST_MILK,
        ST_SUGAR,
        ST_STIR,
        ST_DONE,
        ST_ABORT
    } state_e;

    typedef struct packed {
        logic coffee;
        logic water;
        logic milk;
        logic sugar;
        logic valid;
    } needs_t;

    // Which actuators/ingredients a recipe uses; invalid codes return all zero.
    function automatic needs_t recipe_needs(recipe_e recipe);
        needs_t n;
        n = '0;
        case (recipe)
            RCP_MILK_SUGAR:     begin n.milk = 1'b1; n.sugar = 1'b1; n.valid = 1'b1; end
            RCP_MILK:           begin n.milk = 1'b1; n.valid = 1'b1; end
            RCP_ESPRESSO_SUGAR: begin n.coffee = 1'b1; n.water = 1'b1; n.sugar = 1'b1; n.valid = 1'b1; end
            RCP_ESPRESSO:       begin n.coffee = 1'b1; n.water = 1'b1; n.valid = 1'b1; end
            RCP_CAPPU_SUGAR:    begin n.coffee = 1'b1; n.milk = 1'b1; n.sugar = 1'b1; n.valid = 1'b1; end
            RCP_CAPPU:          begin n.coffee = 1'b1; n.milk = 1'b1; n.valid = 1'b1; end
            default:            n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after the last winner wins.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic                 en,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid
);

    localparam int unsigned IW = $clog2(N);

    // Scan from last_grant+1 with wrap-around and take the first active request.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        if (en) begin
            for (int unsigned i = 0; i < N; i++) begin
                idx = (32'(last_grant) + 32'd1 + i) % N;
                if (!grant_valid && req[IW'(idx)]) begin
                    grant_valid       = 1'b1;
                    grant[IW'(idx)]   = 1'b1;
                    grant_idx         = IW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/brew_sequencer.sv
// Order scheduler and dispense sequencer: arbitrates panel orders, checks
// stock, then walks the BREW/MILK/SUGAR/STIR phases while tracking inventory.
module brew_sequencer
    import coffee_pkg::*;
#(
    parameter int unsigned N_PANELS = 4,
    parameter int unsigned STOCK_W  = 8,
    parameter int unsigned T_BREW   = 8,
    parameter int unsigned T_MILK   = 6,
    parameter int unsigned T_SUGAR  = 2,
    parameter int unsigned T_STIR   = 4,
    parameter int unsigned T_CUP_TO = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_PANELS-1:0]         panel_req,
    input  logic [3*N_PANELS-1:0]       panel_recipe,
    output logic [N_PANELS-1:0]         panel_ack,
    output logic [N_PANELS-1:0]         panel_reject,
    input  logic                        cup_present,
    input  logic                        refill_valid,
    input  logic [1:0]                  refill_sel,
    input  logic [STOCK_W-1:0]          refill_amt,
    output logic                        coffee_dispense,
    output logic                        water_dispense,
    output logic                        milk_dispense,
    output logic                        sugar_dispense,
    output logic                        stirrer_action,
    output logic                        busy,
    output logic                        done,
    output logic                        abort,
    output logic [$clog2(N_PANELS)-1:0] active_panel,
    output logic [STOCK_W-1:0]          stock_beans,
    output logic [STOCK_W-1:0]          stock_milk,
    output logic [STOCK_W-1:0]          stock_sugar
);

    localparam int unsigned PW    = $clog2(N_PANELS);
    localparam int unsigned M1    = (T_BREW > T_MILK) ? T_BREW : T_MILK;
    localparam int unsigned M2    = (T_SUGAR > T_STIR) ? T_SUGAR : T_STIR;
    localparam int unsigned M3    = (M1 > M2) ? M1 : M2;
    localparam int unsigned MAX_T = (M3 > T_CUP_TO) ? M3 : T_CUP_TO;
    localparam int unsigned CNT_W = $clog2(MAX_T + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]       last_grant_q, last_grant_d;
    logic [PW-1:0]       active_d;
    needs_t              need_q, need_d, need_win;
    logic [N_PANELS-1:0] ack_d, reject_d;
    logic                consume_beans, consume_milk, consume_sugar;
    logic                win_ok;

    logic [N_PANELS-1:0] grant;
    logic [PW-1:0]       grant_idx;
    logic                grant_valid;

    rr_arbiter #(.N(N_PANELS)) u_arb (
        .req         (panel_req),
        .en          (state_q == ST_ARB),
        .last_grant  (last_grant_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign need_win = recipe_needs(recipe_e'(panel_recipe[3*int'(grant_idx) +: 3]));
    assign win_ok   = need_win.valid
                    && !(need_win.coffee && stock_beans == '0)
                    && !(need_win.milk   && stock_milk  == '0)
                    && !(need_win.sugar  && stock_sugar == '0);

    // First phase the recipe uses after the given point; STIR always closes.
    function automatic state_e next_phase(state_e s, logic coffee, logic milk, logic sugar);
        state_e nxt;
        nxt = ST_STIR;
        if (s == ST_WAIT_CUP && coffee)
            nxt = ST_BREW;
        else if ((s == ST_WAIT_CUP || s == ST_BREW) && milk)
            nxt = ST_MILK;
        else if (s != ST_SUGAR && sugar)
            nxt = ST_SUGAR;
        return nxt;
    endfunction

    function automatic logic [CNT_W-1:0] phase_load(state_e s);
        case (s)
            ST_BREW:  return CNT_W'(T_BREW - 1);
            ST_MILK:  return CNT_W'(T_MILK - 1);
            ST_SUGAR: return CNT_W'(T_SUGAR - 1);
            ST_STIR:  return CNT_W'(T_STIR - 1);
            default:  return '0;
        endcase
    endfunction

    function automatic logic [STOCK_W-1:0] next_stock(logic [STOCK_W-1:0] cur, logic add,
                                                       logic [STOCK_W-1:0] amt, logic sub);
        logic [STOCK_W:0]   sum;
        logic [STOCK_W-1:0] sat;
        sum = {1'b0, cur} + (add ? {1'b0, amt} : '0);
        sat = sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
        return sat - STOCK_W'(sub);
    endfunction

    // Next-state logic: arbitration, cup wait, timed phases, completion.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        need_d        = need_q;
        active_d      = active_panel;
        ack_d         = '0;
        reject_d      = '0;
        consume_beans = 1'b0;
        consume_milk  = 1'b0;
        consume_sugar = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|panel_req) state_d = ST_ARB;
            end
            ST_ARB: begin
                state_d = ST_IDLE;
                if (grant_valid) begin
                    last_grant_d = grant_idx;
                    if (win_ok) begin
                        ack_d    = grant;
                        need_d   = need_win;
                        active_d = grant_idx;
                        state_d  = ST_WAIT_CUP;
                        cnt_d    = CNT_W'(T_CUP_TO - 1);
                    end else begin
                        reject_d = grant;
                    end
                end
            end
            ST_WAIT_CUP: begin
                if (cup_present) begin
                    consume_beans = need_q.valid & need_q.coffee;
                    consume_milk  = need_q.valid & need_q.milk;
                    consume_sugar = need_q.valid & need_q.sugar;
                    state_d = next_phase(ST_WAIT_CUP, need_q.coffee, need_q.milk, need_q.sugar);
                    cnt_d   = phase_load(state_d);
                end else if (cnt_q == '0) begin
                    state_d = ST_ABORT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_BREW, ST_MILK, ST_SUGAR, ST_STIR: begin
                if (!cup_present) begin
                    state_d = ST_ABORT;
                end else if (cnt_q == '0) begin
                    state_d = (state_q == ST_STIR) ? ST_DONE
                            : next_phase(state_q, need_q.coffee, need_q.milk, need_q.sugar);
                    cnt_d   = phase_load(state_d);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            last_grant_q    <= PW'(N_PANELS - 1);
            need_q          <= '0;
            active_panel    <= '0;
            panel_ack       <= '0;
            panel_reject    <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            abort           <= 1'b0;
            coffee_dispense <= 1'b0;
            water_dispense  <= 1'b0;
            milk_dispense   <= 1'b0;
            sugar_dispense  <= 1'b0;
            stirrer_action  <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            last_grant_q    <= last_grant_d;
            need_q          <= need_d;
            active_panel    <= active_d;
            panel_ack       <= ack_d;
            panel_reject    <= reject_d;
            busy            <= (state_d != ST_IDLE);
            done            <= (state_d == ST_DONE);
            abort           <= (state_d == ST_ABORT);
            coffee_dispense <= (state_d == ST_BREW);
            water_dispense  <= (state_d == ST_BREW) && need_d.water;
            milk_dispense   <= (state_d == ST_MILK);
            sugar_dispense  <= (state_d == ST_SUGAR);
            stirrer_action  <= (state_d == ST_STIR);
        end
    end

    // Inventory: saturating refill first, then the one-unit consumption.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stock_beans <= '0;
            stock_milk  <= '0;
            stock_sugar <= '0;
        end else begin
            stock_beans <= next_stock(stock_beans, refill_valid && refill_sel == ING_BEANS,
                                      refill_amt, consume_beans);
            stock_milk  <= next_stock(stock_milk, refill_valid && refill_sel == ING_MILK,
                                      refill_amt, consume_milk);
            stock_sugar <= next_stock(stock_sugar, refill_valid && refill_sel == ING_SUGAR,
                                      refill_amt, consume_sugar);
        end
    end

endmodule

// File: tb/tb_brew_sequencer.sv
// Directed bench for brew_sequencer: per-recipe vector table plus hand-written
// sequences for round robin, cup removal, saturation and asynchronous reset.
module tb_brew_sequencer;

    localparam int NP = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NP-1:0]   panel_req;
    logic [3*NP-1:0] panel_recipe;
    logic [NP-1:0]   panel_ack;
    logic [NP-1:0]   panel_reject;
    logic            cup_present;
    logic            refill_valid;
    logic [1:0]      refill_sel;
    logic [7:0]      refill_amt;
    logic            coffee_dispense, water_dispense, milk_dispense, sugar_dispense, stirrer_action;
    logic            busy, done, abort;
    logic [1:0]      active_panel;
    logic [7:0]      stock_beans, stock_milk, stock_sugar;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int panel;
        int recipe;
        bit cup;
        int b0, m0, s0;
        bit accept;
        int lat;
        int n_cof, n_wat, n_milk, n_sug, n_stir;
        bit fin_done;
        int b1, m1, s1;
    } vec_t;

    always #5 clk = ~clk;

    brew_sequencer #(
        .N_PANELS(4), .STOCK_W(8), .T_BREW(8), .T_MILK(6),
        .T_SUGAR(2), .T_STIR(4), .T_CUP_TO(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .panel_req(panel_req), .panel_recipe(panel_recipe),
        .panel_ack(panel_ack), .panel_reject(panel_reject),
        .cup_present(cup_present),
        .refill_valid(refill_valid), .refill_sel(refill_sel), .refill_amt(refill_amt),
        .coffee_dispense(coffee_dispense), .water_dispense(water_dispense),
        .milk_dispense(milk_dispense), .sugar_dispense(sugar_dispense),
        .stirrer_action(stirrer_action),
        .busy(busy), .done(done), .abort(abort),
        .active_panel(active_panel),
        .stock_beans(stock_beans), .stock_milk(stock_milk), .stock_sugar(stock_sugar)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        panel_req    = '0;
        panel_recipe = '0;
        cup_present  = 1'b0;
        refill_valid = 1'b0;
        refill_sel   = '0;
        refill_amt   = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic refill(input int sel, input int amt);
        refill_valid = 1'b1;
        refill_sel   = 2'(sel);
        refill_amt   = 8'(amt);
        step();
        refill_valid = 1'b0;
    endtask

    task automatic set_stock(input int b, input int m, input int s);
        if (b > 0) refill(0, b);
        if (m > 0) refill(1, m);
        if (s > 0) refill(2, s);
    endtask

    function automatic logic [4:0] acts();
        return {coffee_dispense, water_dispense, milk_dispense, sugar_dispense, stirrer_action};
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        logic [NP-1:0] onehot;
        int lat, nc, nw, nm, ns, nt, nact;
        bit got_done;
        onehot = '0;
        onehot[v.panel] = 1'b1;
        apply_reset();
        set_stock(v.b0, v.m0, v.s0);
        cup_present  = v.cup;
        panel_recipe = '0;
        panel_recipe[3*v.panel +: 3] = 3'(v.recipe);
        panel_req    = onehot;
        step();
        check($sformatf("v%0d busy_rise", id), 32'(busy), 1);
        check($sformatf("v%0d ack_early", id), 32'(panel_ack | panel_reject), 0);
        step();
        panel_req = '0;
        check($sformatf("v%0d ack", id), 32'(panel_ack), v.accept ? 32'(onehot) : 0);
        check($sformatf("v%0d reject", id), 32'(panel_reject), v.accept ? 0 : 32'(onehot));
        if (v.accept) begin
            check($sformatf("v%0d active_panel", id), 32'(active_panel), v.panel);
            lat = -1; nc = 0; nw = 0; nm = 0; ns = 0; nt = 0; got_done = 1'b0;
            for (int k = 1; k <= 100; k++) begin
                step();
                nc += int'(coffee_dispense);
                nw += int'(water_dispense);
                nm += int'(milk_dispense);
                ns += int'(sugar_dispense);
                nt += int'(stirrer_action);
                if (done || abort) begin
                    lat = k;
                    got_done = done;
                    break;
                end
            end
            check($sformatf("v%0d latency", id), lat, v.lat);
            check($sformatf("v%0d coffee_cycles", id), nc, v.n_cof);
            check($sformatf("v%0d water_cycles", id), nw, v.n_wat);
            check($sformatf("v%0d milk_cycles", id), nm, v.n_milk);
            check($sformatf("v%0d sugar_cycles", id), ns, v.n_sug);
            check($sformatf("v%0d stir_cycles", id), nt, v.n_stir);
            check($sformatf("v%0d done_not_abort", id), 32'(got_done), 32'(v.fin_done));
            step();
            check($sformatf("v%0d idle_after", id), 32'(busy), 0);
        end else begin
            check($sformatf("v%0d busy_after_reject", id), 32'(busy), 0);
            nact = 0;
            for (int k = 0; k < 4; k++) begin
                step();
                nact += int'(|acts()) + int'(busy);
            end
            check($sformatf("v%0d no_activity", id), nact, 0);
        end
        check($sformatf("v%0d beans", id), 32'(stock_beans), v.b1);
        check($sformatf("v%0d milk", id), 32'(stock_milk), v.m1);
        check($sformatf("v%0d sugar", id), 32'(stock_sugar), v.s1);
    endtask

    initial begin
        vec_t vecs[12];
        logic [NP-1:0] exp_g;
        bit found;

        apply_reset();
        check("reset busy", 32'(busy), 0);
        check("reset done_abort", 32'({done, abort}), 0);
        check("reset ack_reject", 32'({panel_ack, panel_reject}), 0);
        check("reset actuators", 32'(acts()), 0);
        check("reset active_panel", 32'(active_panel), 0);
        check("reset stocks", 32'({stock_beans, stock_milk, stock_sugar}), 0);

        //           panel rcp cup  b0 m0 s0 acc lat cof wat mlk sug stir done b1 m1 s1
        vecs[0]  = '{1, 3, 1'b1, 5, 0, 0, 1'b1, 13, 8, 8, 0, 0, 4, 1'b1, 4, 0, 0};
        vecs[1]  = '{0, 0, 1'b1, 0, 3, 3, 1'b1, 13, 0, 0, 6, 2, 4, 1'b1, 0, 2, 2};
        vecs[2]  = '{2, 1, 1'b1, 0, 1, 0, 1'b1, 11, 0, 0, 6, 0, 4, 1'b1, 0, 0, 0};
        vecs[3]  = '{3, 2, 1'b1, 2, 0, 1, 1'b1, 15, 8, 8, 0, 2, 4, 1'b1, 1, 0, 0};
        vecs[4]  = '{0, 4, 1'b1, 1, 1, 1, 1'b1, 21, 8, 0, 6, 2, 4, 1'b1, 0, 0, 0};
        vecs[5]  = '{1, 5, 1'b1, 3, 3, 0, 1'b1, 19, 8, 0, 6, 0, 4, 1'b1, 2, 2, 0};
        vecs[6]  = '{3, 6, 1'b1, 9, 9, 9, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 9, 9, 9};
        vecs[7]  = '{2, 7, 1'b1, 9, 9, 9, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 9, 9, 9};
        vecs[8]  = '{0, 0, 1'b1, 5, 5, 0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 5, 5, 0};
        vecs[9]  = '{1, 3, 1'b1, 0, 5, 5, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 0, 5, 5};
        vecs[10] = '{2, 5, 1'b1, 5, 0, 5, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 5, 0, 5};
        vecs[11] = '{0, 3, 1'b0, 5, 5, 5, 1'b1, 32, 0, 0, 0, 0, 0, 1'b0, 5, 5, 5};

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Request withdrawn before arbitration is ignored.
        apply_reset();
        set_stock(5, 0, 0);
        panel_recipe[2:0] = 3'd3;
        panel_req = 4'b0001;
        step();
        panel_req = '0;
        step();
        check("drop ack_reject", 32'({panel_ack, panel_reject}), 0);
        check("drop busy", 32'(busy), 0);

        // Round robin between panels 0 and 2 holding requests continuously.
        apply_reset();
        set_stock(0, 10, 0);
        cup_present = 1'b1;
        panel_recipe = '0;
        panel_recipe[2:0] = 3'd1;
        panel_recipe[8:6] = 3'd1;
        panel_req = 4'b0101;
        for (int n = 0; n < 4; n++) begin
            exp_g = (n % 2 == 0) ? 4'b0001 : 4'b0100;
            found = 1'b0;
            for (int k = 0; k < 40 && !found; k++) begin
                step();
                if (|panel_ack) found = 1'b1;
            end
            check($sformatf("rr%0d ack_seen", n), 32'(found), 1);
            check($sformatf("rr%0d grant", n), 32'(panel_ack), 32'(exp_g));
            found = 1'b0;
            for (int k = 0; k < 40 && !found; k++) begin
                step();
                if (done) found = 1'b1;
            end
            check($sformatf("rr%0d done_seen", n), 32'(found), 1);
            check($sformatf("rr%0d milk", n), 32'(stock_milk), 9 - n);
        end
        panel_req = '0;

        // Cappuccino with sugar, cup removed during the milk phase.
        apply_reset();
        set_stock(3, 3, 3);
        cup_present = 1'b1;
        panel_recipe = '0;
        panel_recipe[2:0] = 3'd4;
        panel_req = 4'b0001;
        step();
        step();
        check("cupoff ack", 32'(panel_ack), 1);
        panel_req = '0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (milk_dispense) found = 1'b1;
        end
        check("cupoff milk_seen", 32'(found), 1);
        step();
        step();
        check("cupoff still_milk", 32'(milk_dispense), 1);
        cup_present = 1'b0;
        step();
        check("cupoff abort", 32'(abort), 1);
        check("cupoff actuators", 32'(acts()), 0);
        check("cupoff stocks", 32'({stock_beans, stock_milk, stock_sugar}), 32'({8'd2, 8'd2, 8'd2}));
        step();
        check("cupoff abort_pulse", 32'(abort), 0);
        check("cupoff idle", 32'(busy), 0);

        // Ignored refill selector, refill saturation alone and with consumption.
        apply_reset();
        set_stock(200, 0, 0);
        refill(1, 100);
        refill(1, 100);
        check("sat milk_alone", 32'(stock_milk), 200);
        refill(1, 100);
        check("sat milk_clamp", 32'(stock_milk), 255);
        refill(3, 7);
        check("sel3 ignored", 32'({stock_beans, stock_milk, stock_sugar}), 32'({8'd200, 8'd255, 8'd0}));
        apply_reset();
        set_stock(250, 0, 0);
        cup_present = 1'b0;
        panel_recipe = '0;
        panel_recipe[2:0] = 3'd3;
        panel_req = 4'b0001;
        step();
        step();
        check("sat ack", 32'(panel_ack), 1);
        panel_req    = '0;
        cup_present  = 1'b1;
        refill_valid = 1'b1;
        refill_sel   = 2'd0;
        refill_amt   = 8'd10;
        step();
        refill_valid = 1'b0;
        check("sat beans", 32'(stock_beans), 254);
        check("sat brewing", 32'({coffee_dispense, water_dispense}), 3);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("rst actuators", 32'(acts()), 0);
        check("rst busy", 32'(busy), 0);
        check("rst beans", 32'(stock_beans), 0);
        #1 rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/brew_sequencer.md
# brew_sequencer

Order scheduler and dispense sequencer for the coffee machine. It arbitrates brew orders from `N_PANELS` front-panel requesters using round-robin, and checks ingredient stock before accepting an order. It then drives the dispense valves and stirrer through timed phases. It sits between the panel UI logic and the valve/stirrer drivers, and tracks bean, milk and sugar inventory with refill support.

## Interface
- `N_PANELS`, 4: number of order requesters (2..8).
- `STOCK_W`, 8: inventory counter width; counters saturate at 2^STOCK_W-1.
- `T_BREW`, 8: cycles for the coffee/water phase (≥1).
- `T_MILK`, 6: cycles for the milk phase (≥1).
- `T_SUGAR`, 2: cycles for the sugar phase (≥1).
- `T_STIR`, 4: cycles for the stir phase (≥1).
- `T_CUP_TO`, 32: cycles to wait for a cup before abort (≥1).
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `panel_req` in N_PANELS: level order request; held until ack or reject.
- `panel_recipe` in 3*N_PANELS: recipe per panel, in slice [3i+2:3i].
- `panel_ack` out N_PANELS: one-cycle pulse when the order is accepted.
- `panel_reject` out N_PANELS: one-cycle pulse for an invalid recipe or empty stock.
- `cup_present` in 1: cup sensor.
- `refill_valid` in 1: refill strobe.
- `refill_sel` in 2: 0 beans, 1 milk, 2 sugar, 3 ignored.
- `refill_amt` in STOCK_W: units to add.
- `coffee_dispense`, `water_dispense`, `milk_dispense`, `sugar_dispense`, `stirrer_action` out 1 each: actuator enables.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `abort` out 1: one-cycle pulse on cup timeout or cup removal.
- `active_panel` out clog2(N_PANELS): index of the panel being served.
- `stock_beans`, `stock_milk`, `stock_sugar` out STOCK_W each: inventory levels.

## Operation
- Recipes:
  - 0: milk + sugar
  - 1: milk
  - 2: espresso + sugar
  - 3: espresso
  - 4: cappuccino + sugar
  - 5: cappuccino
  - 6–7: invalid
- Espresso uses coffee + water in BREW. Cappuccino uses coffee in BREW (no water), then MILK. Every valid recipe ends with STIR.
- States: IDLE, ARB, WAIT_CUP, BREW, MILK, SUGAR, STIR, DONE, ABORT.
- IDLE: if any `panel_req` is high, go to ARB.
- ARB: the round-robin winner is the first requester starting at `last_grant+1` (wrap). Evaluate the winner's recipe:
  - Invalid recipe, or a required stock is 0: pulse `panel_reject[w]` and return to IDLE. `last_grant` updates anyway.
  - Otherwise: pulse `panel_ack[w]`, latch the recipe, set `active_panel=w` and go to WAIT_CUP.
- WAIT_CUP: when `cup_present` is high, decrement each required stock by 1 and go to the first phase of the recipe. After `T_CUP_TO` cycles without a cup, go to ABORT with no stock consumed.
- Phase order is BREW, MILK, SUGAR, STIR. Phases the recipe does not use are skipped with zero cycles.
- Each phase lasts exactly its T_* cycles. A down-counter is loaded with T-1 on entry.
- Cup dropping during any phase: go to ABORT next cycle. Consumed stock is not refunded.
- DONE and ABORT each last 1 cycle, then IDLE.
- Refill: `stock += refill_amt`, saturating. When a refill and a consumption hit the same ingredient in the same cycle, the result is sat(stock + amt) − 1.
- Reset values: all outputs 0, `last_grant = N_PANELS-1` (so panel 0 wins first), all stocks 0.

## Timing
- All outputs are registered and decoded from state. Each actuator is high exactly on the cycles its phase is active.
- The `panel_req` to `panel_ack` latency from IDLE is 2 cycles; `busy` rises 1 cycle after the request.
- `done` is high the cycle after the last STIR cycle. The next order can enter ARB no sooner than 2 cycles after `done`.
- Requests are sampled only in IDLE/ARB. A request dropped before ARB is ignored.
- Reset asserted mid-brew clears all actuators immediately (asynchronously).

## Structure
- Package `coffee_pkg` holds:
  - the recipe enum (3-bit)
  - the ingredient index constants (`ING_BEANS`, `ING_MILK`, `ING_SUGAR`)
  - the state enum
  - function `recipe_needs(recipe)`, returning a {coffee, water, milk, sugar, valid} struct
- Sub-module `rr_arbiter` (N requesters, enable, last-grant pointer, one-hot/index grant).

## Test plan
- Reset, refill beans=5, panel 1 recipe 3, cup present: ack[1] 2 cycles after req. Coffee+water high 8 cycles, stirrer 4 cycles, then `done`. Beans = 4.
- Panels 0 and 2 request recipe 1 continuously with milk stock 10: grants alternate 0, 2, 0, 2. Each grant decrements milk by 1.
- Recipe 6 on panel 3: `panel_reject[3]` pulse, no actuator activity. Same result for recipe 0 with sugar=0.
- Order accepted, cup never present: `abort` after 32 cycles, stocks unchanged.
- Recipe 4, cup removed during MILK: `abort` next cycle, all actuators 0, beans/milk/sugar each decremented by 1.
- Beans = 250, refill 10 in the same cycle as consumption: beans = 254. `rst_n` low mid-BREW: outputs 0 immediately.
